// File: rtl/sram_march_bist.sv
// March C- BIST initiator for the single-port sync_sram: 10N ops per pass, sticky pass/fail, first-failure capture.
// Optional: define BIST_CHECKERBOARD_EN to append a second pass with a 0101... background.
module sram_march_bist #(
    parameter int ADDRESS_BIT = 4,
    parameter int DATA_BIT    = 8
) (
    input  logic                   ck,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDRESS_BIT-1:0] fail_addr,
    output logic [DATA_BIT-1:0]    fail_data,
    output logic                   sram_cs,
    output logic                   sram_we,
    output logic [ADDRESS_BIT-1:0] sram_addr,
    output logic [DATA_BIT-1:0]    sram_wdata,
    input  logic [DATA_BIT-1:0]    sram_rdata
);

    typedef enum logic [3:0] {
        IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRESS_BIT-1:0] addr_q, addr_d;
    logic                   phase_q, phase_d;   // 0 = read half, 1 = write half of an r/w pair

    logic                   descending;
    logic                   single_op;
    logic                   op_we;
    logic                   last_op_here;
    logic                   at_end;
    logic [DATA_BIT-1:0]    bg0, bg1, rd_exp, wr_val;

    logic                   rd_valid_q;
    logic [DATA_BIT-1:0]    exp_data_q;
    logic [ADDRESS_BIT-1:0] exp_addr_q;

`ifdef BIST_CHECKERBOARD_EN
    function automatic logic [DATA_BIT-1:0] checker_bg();
        logic [DATA_BIT-1:0] p;
        for (int i = 0; i < DATA_BIT; i++) p[i] = (i % 2 == 0);
        return p;
    endfunction

    localparam logic [DATA_BIT-1:0] CHECKER = checker_bg();

    logic pass_q, pass_d;
    assign bg0 = pass_q ? CHECKER : '0;
`else
    assign bg0 = '0;
`endif

    assign bg1          = ~bg0;
    assign descending   = (state_q == M3) || (state_q == M4);
    assign single_op    = (state_q == M0) || (state_q == M5);
    assign op_we        = (state_q == M0) ? 1'b1 : (state_q == M5) ? 1'b0 : phase_q;
    assign last_op_here = single_op || phase_q;
    assign at_end       = descending ? (addr_q == '0) : (addr_q == '1);
    assign rd_exp       = ((state_q == M2) || (state_q == M4)) ? bg1 : bg0;
    assign wr_val       = ((state_q == M1) || (state_q == M3)) ? bg1 : bg0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            phase_q <= 1'b0;
`ifdef BIST_CHECKERBOARD_EN
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
`ifdef BIST_CHECKERBOARD_EN
            pass_q  <= pass_d;
`endif
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
`ifdef BIST_CHECKERBOARD_EN
        pass_d  = pass_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = M0;
                    addr_d  = '0;
                    phase_d = 1'b0;
`ifdef BIST_CHECKERBOARD_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            DRAIN: state_d = DONE;
            default: begin
                if (!last_op_here) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!at_end) begin
                        addr_d = descending ? addr_q - ADDRESS_BIT'(1) : addr_q + ADDRESS_BIT'(1);
                    end else begin
                        case (state_q)
                            M0:      state_d = M1;
                            M1:      state_d = M2;
                            M2:      state_d = M3;
                            M3:      state_d = M4;
                            M4:      state_d = M5;
                            default: begin
`ifdef BIST_CHECKERBOARD_EN
                                if (!pass_q) begin
                                    state_d = M0;
                                    pass_d  = 1'b1;
                                end else begin
                                    state_d = DRAIN;
                                end
`else
                                state_d = DRAIN;
`endif
                            end
                        endcase
                        // Each element starts from its own end of the address space.
                        addr_d = ((state_d == M3) || (state_d == M4)) ? '1 : '0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state_q)
            M0, M1, M2, M3, M4, M5: begin
                busy       = 1'b1;
                sram_cs    = 1'b1;
                sram_we    = op_we;
                sram_addr  = addr_q;
                sram_wdata = op_we ? wr_val : '0;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Read data returns one edge after the read is sampled, so expectations ride one stage behind.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            exp_data_q <= '0;
            exp_addr_q <= '0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else begin
            rd_valid_q <= sram_cs && !sram_we;
            exp_data_q <= rd_exp;
            exp_addr_q <= addr_q;
            if (((state_q == IDLE) || (state_q == DONE)) && start) begin
                fail <= 1'b0;
            end else if (rd_valid_q && (sram_rdata != exp_data_q)) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= exp_addr_q;
                    fail_data <= sram_rdata;
                end
            end
        end
    end

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Built-in self-test initiator for the single-port synchronous SRAM (the `sync_sram` block); drives its ck/addr/cs/we/wdata interface and checks rdata.
- Runs a March C- algorithm over the full address space, reports pass/fail and captures the first failing location.
- Sits beside the SRAM; a mux selects between functional traffic and this block (the mux is outside scope).

Parameters:
- ADDRESS_BIT, 4, SRAM address width; N = 2^ADDRESS_BIT words.
- DATA_BIT, 8, SRAM word width.

Ports:
- ck  input  1  clock; all logic on posedge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  run request; sampled only in IDLE or DONE.
- busy  output  1  high while a run is in progress.
- done  output  1  sticky completion flag; cleared by the next accepted start.
- fail  output  1  sticky mismatch flag; valid when done=1.
- fail_addr  output  ADDRESS_BIT  address of the first mismatching read.
- fail_data  output  DATA_BIT  rdata of the first mismatching read.
- sram_cs  output  1  chip select, active-high.
- sram_we  output  1  1 = write, 0 = read (when sram_cs=1).
- sram_addr  output  ADDRESS_BIT  SRAM address.
- sram_wdata  output  DATA_BIT  SRAM write data.
- sram_rdata  input  DATA_BIT  SRAM read data.

Behaviour:
- SRAM contract:
  - SRAM samples cs/we/addr/wdata on posedge.
  - A read sampled at edge P returns data on rdata after P; this block samples it at P+1.
- Reset: all outputs 0; state IDLE; sram_cs=0.
- States: IDLE, M0..M5, DRAIN, DONE.
- March elements, with B0 = all-zeros and B1 = ~B0:
  - M0: ascending, w B0.
  - M1: ascending, r B0 then w B1.
  - M2: ascending, r B1 then w B0.
  - M3: descending, r B0 then w B1.
  - M4: descending, r B1 then w B0.
  - M5: ascending, r B0.
- Sequencing:
  - Exactly one SRAM operation per cycle, sram_cs=1 throughout M0..M5.
  - No idle cycles between elements.
  - Read/write pairs use the same address on consecutive cycles.
  - Ascending order is 0..N-1; descending order is N-1..0.
  - The address counter wraps at the element boundary and reloads to the element's start value.
  - Total 10N operations.
- Timing:
  - start sampled high in IDLE/DONE at edge P0: busy=1, done=0, fail=0 after P0, and the first op is driven.
  - Operation k is sampled by the SRAM at P(k+1).
  - After the last op: sram_cs=0, state DRAIN.
  - At P(10N+1) the final compare occurs, then done=1 and busy=0 (state DONE). N=16 gives 161 cycles.
- Compare pipeline:
  - Each read registers an expected value and address alongside a 1-bit read-valid.
  - At the next edge, if read-valid and rdata != expected: fail=1.
  - fail_addr/fail_data are loaded only if fail was 0 (first failure kept).
  - The run always continues to completion.
- Outputs idle in IDLE, DRAIN and DONE: sram_cs=0, sram_we=0; sram_addr/sram_wdata hold 0.
- start while busy is ignored. start held high in DONE restarts immediately.
- Reset mid-run: immediate abort; all outputs 0 asynchronously. No partial status is retained.

Optional Feature:
- Macro: BIST_CHECKERBOARD_EN.
- Defined:
  - After M5 of pass 1 (B0 = 0), a second full March C- pass follows with no gap.
  - Pass 2 uses B0 = alternating 0101… (LSB=1, 0x55 for 8 bits) and B1 = ~B0.
  - done rises at P(20N+1), i.e. 321 cycles for N=16.
  - fail_addr/fail_data capture the first failure across both passes.
- Undefined: single pass with the all-zeros/all-ones background only; no pass-2 logic is synthesized.

Test Plan:
- Fault-free SRAM model, N=16, start pulse -> done=1 exactly 161 cycles after start edge, fail=0; 80 writes and 80 reads observed; M0 issues writes only (sram_we=1, wdata=0x00) at addresses 0..15.
- Stuck-at-0 on bit 3 at address 5 -> fail=1, fail_addr=5, fail_data=0xF7 (first r1 in M2); done still at cycle 161.
- Address-decoder fault (addr bit 0 ignored) -> fail=1, fail_addr=1, fail_data=0xFF (M1 read).
- rst_n low at cycle 50 -> busy/done/fail/sram_cs all 0 immediately; rst_n high then start -> clean run, done at 161, fail=0.
- start pulsed at cycles 10 and 100 during a run -> ignored, done still at 161; start in DONE -> done/fail cleared next edge, new run completes at +161.
- With BIST_CHECKERBOARD_EN, fault-free -> done at 321; pass-2 M0 wdata=0x55, M1 writes 0xAA; stuck-at-0 bit 0 at address 2 -> fail_addr=2, fail_data=0xFE.
